// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers in bursts.
// Optional per-requester beat statistics are enabled with `define FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_full,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         beat_count
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W:0] MAX_BURST_C = (CNT_W + 1)'(MAX_BURST);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [IDX_W-1:0]      sel_idx;
  logic                  sel_found;
  logic                  owner_valid, owner_last;
  logic [DATA_WIDTH-1:0] owner_data;
  logic                  beat, burst_end;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Search upward from rr_ptr with wrap for the first valid requester.
  always_comb begin
    logic [IDX_W-1:0] cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = wrap_add(rr_ptr_q, k);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        owner_valid = req_valid[i];
        owner_last  = req_last[i];
        owner_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Write-side outputs are forced quiet while reset is asserted so no beat leaks out.
  assign beat         = rst_n && (state_q == GRANT) && owner_valid && !fifo_full;
  assign burst_end    = owner_last || (({1'b0, beat_cnt_q} + (CNT_W + 1)'(1)) == MAX_BURST_C);
  assign fifo_wr_en   = beat;
  assign fifo_wr_data = beat ? owner_data : '0;
  assign req_ready    = (rst_n && (state_q == GRANT) && !fifo_full) ? grant_q : '0;
  assign grant        = grant_q;
  assign busy         = (state_q == GRANT);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d          = GRANT;
          owner_d          = sel_idx;
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          beat_cnt_d       = '0;
        end
      end
      GRANT: begin
        if (beat) begin
          if (burst_end) begin
            state_d    = IDLE;
            grant_d    = '0;
            beat_cnt_d = '0;
            rr_ptr_d   = wrap_add(owner_q, 1);
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] stat_q [NUM_REQ];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rst_n) begin
        stat_q[i] <= '0;
      end else if (beat && (owner_q == IDX_W'(i))) begin
        stat_q[i] <= sat_inc(stat_q[i]);
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign beat_count[g*16 +: 16] = stat_q[g];
  end
`endif

endmodule
